// File: rtl/hamming_frame_tx.sv
// Transmit framer: latches one ciphertext block, Hamming(21,16)-encodes each 16-bit word
// and streams the codewords MSB first as one serial frame with valid/ready handshakes.
module hamming_frame_tx #(
  parameter int N_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [16*N_WORDS-1:0]   in_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    tx_bit,
  output logic                    tx_sof,
  output logic                    tx_eof
);

  localparam int BW  = 16 * N_WORDS;
  localparam int WCW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [4:0]     LAST_BIT  = 5'd20;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(N_WORDS - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [20:0]    shreg_q, shreg_d;
  logic [4:0]     bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [BW-1:0]  block_q, block_d;

  logic           last_word;
  logic           xfer;

  // Codeword c[1:21] is returned with c[1] in the MSB so a left shift sends c[1] first.
  function automatic logic [20:0] hamming_encode(input logic [15:0] w);
    logic [1:21] c;
    c      = '0;
    c[3]   = w[15];
    c[5]   = w[14];
    c[6]   = w[13];
    c[7]   = w[12];
    c[9]   = w[11];
    c[10]  = w[10];
    c[11]  = w[9];
    c[12]  = w[8];
    c[13]  = w[7];
    c[14]  = w[6];
    c[15]  = w[5];
    c[17]  = w[4];
    c[18]  = w[3];
    c[19]  = w[2];
    c[20]  = w[1];
    c[21]  = w[0];
    c[1]   = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11] ^ c[13] ^ c[15] ^ c[17] ^ c[19] ^ c[21];
    c[2]   = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11] ^ c[14] ^ c[15] ^ c[18] ^ c[19];
    c[4]   = c[5] ^ c[6] ^ c[7] ^ c[12] ^ c[13] ^ c[14] ^ c[15] ^ c[20] ^ c[21];
    c[8]   = c[9] ^ c[10] ^ c[11] ^ c[12] ^ c[13] ^ c[14] ^ c[15];
    c[16]  = c[17] ^ c[18] ^ c[19] ^ c[20] ^ c[21];
    return c;
  endfunction

  assign last_word = (word_cnt_q == LAST_WORD);
  assign xfer      = (state_q == ST_SHIFT) && tx_ready;

  // NOTE: every register, including the block holding register, is cleared by the async
  // reset with non-blocking assignments so a dropped frame leaves no stale state behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      block_q    <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      block_q    <= block_d;
    end
  end

  // NOTE: all next-state values default to the current value first, so no path infers a latch.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    block_d    = block_q;

    if (state_q == ST_IDLE) begin
      if (in_valid) begin
        // Word 0 goes straight into the shifter; the rest wait MS-first in block_q.
        shreg_d    = hamming_encode(in_data[BW-1 -: 16]);
        block_d    = in_data << 16;
        bit_cnt_d  = '0;
        word_cnt_d = '0;
        state_d    = ST_SHIFT;
      end
    end else if (xfer) begin
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        if (last_word) begin
          shreg_d    = '0;
          word_cnt_d = '0;
          state_d    = ST_IDLE;
        end else begin
          shreg_d    = hamming_encode(block_q[BW-1 -: 16]);
          block_d    = block_q << 16;
          word_cnt_d = word_cnt_q + 1'b1;
        end
      end else begin
        shreg_d   = {shreg_q[19:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end
  end

  always_comb begin
    in_ready = 1'b0;
    tx_valid = 1'b0;
    tx_bit   = 1'b0;
    tx_sof   = 1'b0;
    tx_eof   = 1'b0;
    if (state_q == ST_IDLE) begin
      in_ready = 1'b1;
    end else begin
      tx_valid = 1'b1;
      tx_bit   = shreg_q[20];
      tx_sof   = (word_cnt_q == '0) && (bit_cnt_q == '0);
      tx_eof   = last_word && (bit_cnt_q == LAST_BIT);
    end
  end

endmodule

// File: tb/tb_hamming_frame_tx.sv
// Directed bench for hamming_frame_tx: hand-computed frames, stalls, back-to-back blocks,
// mid-frame reset, and single-error recovery through an independent Hamming decoder.
module tb_hamming_frame_tx;

  localparam int N_WORDS = 4;

  localparam logic [83:0] FRAME_A = {21'h0FFFFF, 21'h000000, 21'h1C0000, 21'h000000};
  localparam logic [83:0] FRAME_B = {21'h1C0000, 21'h0FFFFF, 21'h000000, 21'h000000};
  localparam logic [63:0] BLOCK_A = 64'hFFFF_0000_8000_0000;
  localparam logic [63:0] BLOCK_B = 64'h8000_FFFF_0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_bit;
  logic        tx_sof;
  logic        tx_eof;

  int n_checks = 0;
  int n_errors = 0;

  hamming_frame_tx #(.N_WORDS(N_WORDS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_bit   (tx_bit),
    .tx_sof   (tx_sof),
    .tx_eof   (tx_eof)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [83:0] got, input logic [83:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Presents a block at a negedge and returns at the negedge after the accepting edge.
  task automatic accept(input string tag, input logic [63:0] blk,
                        input bit keep_valid, input logic [63:0] next_blk);
    int w = 0;
    in_valid = 1'b1;
    in_data  = blk;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, " accept_wait"}, 84'(w < 50), 84'(1));
    @(negedge clk);
    if (keep_valid) in_data = next_blk;
    else in_valid = 1'b0;
    check({tag, " valid_latency1"}, 84'(tx_valid), 84'(1));
    check({tag, " sof_first"}, 84'(tx_sof), 84'(1));
  endtask

  // Collects one frame; cycle 0 is the first tx_valid cycle. With toggle, tx_ready
  // runs 0,1,0,1... from that cycle onward.
  task automatic collect(input string tag, input bit toggle,
                         output logic [83:0] bits, output int vcycles);
    int   n = 0;
    int   cyc = 0;
    int   sof_bad = 0, eof_bad = 0, hold_bad = 0, rdy_bad = 0;
    logic pb = 1'b0, ps = 1'b0, pe = 1'b0;
    bit   pstall = 1'b0;
    bits    = '0;
    vcycles = 0;
    while (n < 84 && cyc < 400) begin
      tx_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      if (tx_valid) begin
        vcycles++;
        if (pstall && ({tx_bit, tx_sof, tx_eof} !== {pb, ps, pe})) hold_bad++;
        if (in_ready) rdy_bad++;
        if (tx_ready) begin
          bits = {bits[82:0], tx_bit};
          if (tx_sof !== (n == 0))  sof_bad++;
          if (tx_eof !== (n == 83)) eof_bad++;
          n++;
        end
        pstall = !tx_ready;
        pb = tx_bit;
        ps = tx_sof;
        pe = tx_eof;
      end
      cyc++;
      @(negedge clk);
    end
    tx_ready = 1'b1;
    check({tag, " nbits"},     84'(n),        84'(84));
    check({tag, " sof_place"}, 84'(sof_bad),  84'(0));
    check({tag, " eof_place"}, 84'(eof_bad),  84'(0));
    check({tag, " in_ready_low"}, 84'(rdy_bad), 84'(0));
    if (toggle) check({tag, " stall_hold"}, 84'(hold_bad), 84'(0));
  endtask

  task automatic check_idle(input string tag);
    check({tag, " idle_valid"}, 84'(tx_valid), 84'(0));
    check({tag, " idle_ready"}, 84'(in_ready), 84'(1));
  endtask

  // Independent syndrome decoder for a 21-bit group (c[1] in the MSB).
  function automatic logic [15:0] hamming_decode(input logic [20:0] grp);
    logic [1:21] c;
    logic [4:0]  syn;
    logic [4:0]  idx;
    logic [15:0] w;
    c   = grp;
    syn = '0;
    w   = '0;
    for (int i = 1; i <= 21; i++) begin
      idx = 5'(i);
      if (c[idx]) syn = syn ^ idx;
    end
    if (syn >= 5'd1 && syn <= 5'd21) c[syn] = ~c[syn];
    for (int i = 1; i <= 21; i++) begin
      idx = 5'(i);
      if ((idx & (idx - 5'd1)) != 5'd0) w = {w[14:0], c[idx]};
    end
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [83:0] bits;
    int          vc;
    logic [63:0] blk;
    logic [20:0] grp;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    tx_ready = 1'b1;
    #1;
    check("reset in_ready", 84'(in_ready), 84'(1));
    check("reset tx_valid", 84'(tx_valid), 84'(0));
    check("reset tx_bit",   84'(tx_bit),   84'(0));
    check("reset tx_sof",   84'(tx_sof),   84'(0));
    check("reset tx_eof",   84'(tx_eof),   84'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All-zero block streams 84 zero bits back to back.
    accept("t1", 64'h0, 1'b0, 64'h0);
    collect("t1", 1'b0, bits, vc);
    check("t1 frame", bits, 84'h0);
    check("t1 cycles", 84'(vc), 84'(84));
    check_idle("t1");
    @(negedge clk);

    accept("t2", BLOCK_A, 1'b0, 64'h0);
    collect("t2", 1'b0, bits, vc);
    check("t2 frame", bits, FRAME_A);
    check_idle("t2");
    @(negedge clk);

    // Alternating back-pressure doubles the frame length without changing its content.
    accept("t3", BLOCK_A, 1'b0, 64'h0);
    collect("t3", 1'b1, bits, vc);
    check("t3 frame", bits, FRAME_A);
    check("t3 cycles", 84'(vc), 84'(168));
    check_idle("t3");
    @(negedge clk);

    // in_valid held high: B waits for A, and A ignores in_data changing under it.
    accept("t4a", BLOCK_A, 1'b1, BLOCK_B);
    collect("t4a", 1'b0, bits, vc);
    check("t4a frame", bits, FRAME_A);
    check("t4 gap_valid", 84'(tx_valid), 84'(0));
    check("t4 gap_ready", 84'(in_ready), 84'(1));
    @(negedge clk);
    check("t4b valid", 84'(tx_valid), 84'(1));
    check("t4b sof",   84'(tx_sof),   84'(1));
    in_valid = 1'b0;
    collect("t4b", 1'b0, bits, vc);
    check("t4b frame", bits, FRAME_B);
    check_idle("t4b");
    @(negedge clk);

    // Reset after bit 40 drops the frame at once.
    accept("t5", BLOCK_A, 1'b0, 64'h0);
    repeat (41) @(negedge clk);
    check("t5 pre_reset_valid", 84'(tx_valid), 84'(1));
    rst_n = 1'b0;
    #1;
    check("t5 rst_valid", 84'(tx_valid), 84'(0));
    check("t5 rst_ready", 84'(in_ready), 84'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("t5 post");
    accept("t5n", BLOCK_B, 1'b0, 64'h0);
    collect("t5n", 1'b0, bits, vc);
    check("t5n frame", bits, FRAME_B);
    @(negedge clk);

    // Random blocks, one flipped bit per group, must decode back to the original words.
    for (int r = 0; r < 3; r++) begin
      blk = {$urandom, $urandom};
      accept("t6", blk, 1'b0, 64'h0);
      collect("t6", 1'b0, bits, vc);
      for (int g = 0; g < N_WORDS; g++) begin
        grp = bits[83 - 21*g -: 21];
        grp = grp ^ (21'd1 << $urandom_range(0, 20));
        check($sformatf("t6 blk%0d word%0d", r, g),
              84'(hamming_decode(grp)), 84'(blk[63 - 16*g -: 16]));
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
